// File: rtl/osd_pkg.sv
`default_nettype none
// ============================================================
// osd_pkg : shared OSD constants, FSM encoding, TEP list sizing
// Revision: 1.0
// ============================================================
package osd_pkg;

   localparam int OSD_K = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ORD0 = 3'd1,
      ST_ORD1 = 3'd2,
      ST_ORD2 = 3'd3,
      ST_DONE = 3'd4
   } tep_state_e;

   // Number of patterns in a full sequence; order values above 2 act as 2.
   function automatic int num_teps(input int k, input int ord);
      if (ord == 0)
         return 1;
      else if (ord == 1)
         return 1 + k;
      else
         return 1 + k + (k * (k - 1)) / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/osd_pair_counter.sv
`default_nettype none
// ============================================================
// osd_pair_counter : (i,j) lexicographic pair stepper, i<j;
// steps i alone when i_pair is low. Revision: 1.0
// ============================================================
module osd_pair_counter #(
   parameter int K     = 8,
   parameter int PTR_W = (K > 1) ? $clog2(K) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_adv,
   input  logic             i_pair,
   output logic [PTR_W-1:0] o_i_nxt,
   output logic [PTR_W-1:0] o_j_nxt,
   output logic             o_last
);

   localparam logic [PTR_W-1:0] C_KM1 = PTR_W'(K - 1);
   localparam logic [PTR_W-1:0] C_KM2 = PTR_W'(K - 2);
   localparam logic [PTR_W-1:0] C_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] C_TWO = PTR_W'(2);

   logic [PTR_W-1:0] r_i;
   logic [PTR_W-1:0] r_j;
   logic [PTR_W-1:0] w_i_nxt;
   logic [PTR_W-1:0] w_j_nxt;

   always_comb begin
      w_i_nxt = r_i;
      w_j_nxt = r_j;
      if (i_load) begin
         w_i_nxt = '0;
         w_j_nxt = C_ONE;
      end else if (i_adv) begin
         if (!i_pair) begin
            w_i_nxt = r_i + C_ONE;
         end else if (r_j != C_KM1) begin
            w_j_nxt = r_j + C_ONE;
         end else begin
            w_i_nxt = r_i + C_ONE;
            w_j_nxt = r_i + C_TWO;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_i <= '0;
         r_j <= C_ONE;
      end else begin
         r_i <= w_i_nxt;
         r_j <= w_j_nxt;
      end
   end

   assign o_i_nxt = w_i_nxt;
   assign o_j_nxt = w_j_nxt;
   assign o_last  = i_pair ? ((r_i == C_KM2) && (r_j == C_KM1)) : (r_i == C_KM1);

endmodule
`default_nettype wire

// File: rtl/osd_tep_scheduler.sv
`default_nettype none
// ============================================================
// osd_tep_scheduler : emits order-0/1/2 test-error patterns over
// a valid/ready stream. Revision: 1.0
// ============================================================
module osd_tep_scheduler
   import osd_pkg::*;
#(
   parameter int K     = OSD_K,
   parameter int IDX_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       order,
   input  logic             abort,
   output logic [K-1:0]     tep,
   output logic             tep_is_2bit,
   output logic [IDX_W-1:0] tep_index,
   output logic             tep_valid,
   input  logic             tep_ready,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] tep_count
);

   localparam int PTR_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [K-1:0]     C_ONE_HOT = K'(1);
   localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);

   tep_state_e       r_state;
   logic [1:0]       r_max_ord;
   logic [K-1:0]     r_tep;
   logic             r_is2;
   logic [IDX_W-1:0] r_index;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic [IDX_W-1:0] r_count;

   logic             w_accept;
   logic             w_pair;
   logic             w_load;
   logic             w_adv;
   logic             w_last;
   logic [PTR_W-1:0] w_i_nxt;
   logic [PTR_W-1:0] w_j_nxt;
   logic [IDX_W-1:0] w_index_inc;

   // abort wins over a same-cycle handshake
   assign w_accept    = r_valid & tep_ready & ~abort;
   assign w_pair      = (r_state == ST_ORD2);
   assign w_load      = w_accept & ((r_state == ST_ORD0) |
                        ((r_state == ST_ORD1) & w_last & (r_max_ord == 2'd2)));
   assign w_adv       = w_accept & ~w_last & ((r_state == ST_ORD1) | (r_state == ST_ORD2));
   assign w_index_inc = r_index + C_IDX_ONE;

   osd_pair_counter #(
      .K     (K),
      .PTR_W (PTR_W)
   ) u_pair (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_adv   (w_adv),
      .i_pair  (w_pair),
      .o_i_nxt (w_i_nxt),
      .o_j_nxt (w_j_nxt),
      .o_last  (w_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_max_ord <= 2'd0;
         r_tep     <= '0;
         r_is2     <= 1'b0;
         r_index   <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_count   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_ORD0;
                  r_max_ord <= (order == 2'd3) ? 2'd2 : order;
                  r_tep     <= '0;
                  r_is2     <= 1'b0;
                  r_index   <= '0;
                  r_valid   <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            ST_ORD0, ST_ORD1, ST_ORD2: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
               end else if (w_accept) begin
                  r_index <= w_index_inc;
                  if ((r_state == ST_ORD0 && r_max_ord == 2'd0) ||
                      (r_state == ST_ORD1 && w_last && r_max_ord == 2'd1) ||
                      (r_state == ST_ORD2 && w_last)) begin
                     r_state <= ST_DONE;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_count <= w_index_inc;
                  end else if (r_state == ST_ORD0) begin
                     r_state <= ST_ORD1;
                     r_tep   <= C_ONE_HOT << w_i_nxt;
                  end else if (r_state == ST_ORD1 && w_last) begin
                     r_state <= ST_ORD2;
                     r_is2   <= 1'b1;
                     r_tep   <= (C_ONE_HOT << w_i_nxt) | (C_ONE_HOT << w_j_nxt);
                  end else if (r_state == ST_ORD1) begin
                     r_tep   <= C_ONE_HOT << w_i_nxt;
                  end else begin
                     r_tep   <= (C_ONE_HOT << w_i_nxt) | (C_ONE_HOT << w_j_nxt);
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign tep         = r_tep;
   assign tep_is_2bit = r_is2;
   assign tep_index   = r_index;
   assign tep_valid   = r_valid;
   assign busy        = r_busy;
   assign done        = r_done;
   assign tep_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_osd_tep_scheduler.sv
`default_nettype none
// ============================================================
// tb_osd_tep_scheduler : scoreboard bench for osd_tep_scheduler, K=8
// Revision: 1.0
// ============================================================
module tb_osd_tep_scheduler;

   localparam int K     = 8;
   localparam int IDX_W = 16;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [1:0]       order;
   logic             abort;
   logic [K-1:0]     tep;
   logic             tep_is_2bit;
   logic [IDX_W-1:0] tep_index;
   logic             tep_valid;
   logic             tep_ready;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] tep_count;

   typedef struct {
      logic [K-1:0]     tep;
      logic             is2;
      logic [IDX_W-1:0] idx;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   osd_tep_scheduler #(.K(K), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .order       (order),
      .abort       (abort),
      .tep         (tep),
      .tep_is_2bit (tep_is_2bit),
      .tep_index   (tep_index),
      .tep_valid   (tep_valid),
      .tep_ready   (tep_ready),
      .busy        (busy),
      .done        (done),
      .tep_count   (tep_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference list: order 0, then single bits, then pairs i<j in lexicographic order.
   task automatic push_expected(input int ord);
      int   eff;
      exp_t e;
      eff = (ord == 3) ? 2 : ord;
      q.delete();
      e.tep = '0; e.is2 = 1'b0; e.idx = '0;
      q.push_back(e);
      if (eff >= 1)
         for (int i = 0; i < K; i++) begin
            e.tep = '0; e.tep[i] = 1'b1; e.is2 = 1'b0; e.idx = IDX_W'(q.size());
            q.push_back(e);
         end
      if (eff == 2)
         for (int i = 0; i < K; i++)
            for (int j = i + 1; j < K; j++) begin
               e.tep = '0; e.tep[i] = 1'b1; e.tep[j] = 1'b1; e.is2 = 1'b1;
               e.idx = IDX_W'(q.size());
               q.push_back(e);
            end
   endtask

   task automatic do_start(input int ord);
      @(negedge clk);
      order = 2'(ord);
      start = 1'b1;
   endtask

   // Consumes the running sequence; aborts when tep_index hits abort_idx,
   // pulses start when tep_index hits pulse_idx.
   task automatic drain(input bit rnd, input int abort_idx, input int pulse_idx,
                        output int accepts, output int dones);
      logic [K-1:0]     hold_tep;
      logic [IDX_W-1:0] hold_idx;
      bit stalled, seen_busy, accepted_prev, aborted_prev, finished;
      exp_t e;
      accepts = 0; dones = 0;
      stalled = 0; seen_busy = 0; accepted_prev = 0; aborted_prev = 0; finished = 0;
      hold_tep = '0; hold_idx = '0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (done) dones++;
         if (accepted_prev && q.size() == 0) begin
            n_checks++;
            if (done !== 1'b1 || tep_valid !== 1'b0)
               $display("FAIL done_after_last: done=%b valid=%b required done=1 valid=0", done, tep_valid);
            else n_pass++;
         end
         if (aborted_prev) begin
            n_checks++;
            if (busy !== 1'b0 || tep_valid !== 1'b0 || done !== 1'b0)
               $display("FAIL abort_idle: busy=%b valid=%b done=%b required 0/0/0", busy, tep_valid, done);
            else n_pass++;
         end
         accepted_prev = 0;
         aborted_prev  = 0;
         if (busy) seen_busy = 1;
         if (seen_busy && !busy) begin
            finished = 1;
         end else if (tep_valid) begin
            if (stalled) begin
               n_checks++;
               if (tep !== hold_tep || tep_index !== hold_idx)
                  $display("FAIL stall_hold: tep=%h idx=%0d required tep=%h idx=%0d", tep, tep_index, hold_tep, hold_idx);
               else n_pass++;
            end
            n_checks++;
            if (q.size() == 0) begin
               $display("FAIL extra_pattern: tep=%h idx=%0d required no pattern", tep, tep_index);
            end else begin
               e = q[0];
               if (tep !== e.tep || tep_is_2bit !== e.is2 || tep_index !== e.idx)
                  $display("FAIL pattern: tep=%h is2=%b idx=%0d required tep=%h is2=%b idx=%0d",
                           tep, tep_is_2bit, tep_index, e.tep, e.is2, e.idx);
               else n_pass++;
            end
            tep_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (int'(tep_index) == pulse_idx) begin
               start = 1'b1;
               order = 2'd0;
            end
            if (int'(tep_index) == abort_idx) begin
               abort = 1'b1;
               tep_ready = 1'b1;
               aborted_prev = 1;
               stalled = 0;
            end else if (tep_ready) begin
               if (q.size() > 0) void'(q.pop_front());
               accepts++;
               accepted_prev = 1;
               stalled = 0;
            end else begin
               stalled  = 1;
               hold_tep = tep;
               hold_idx = tep_index;
            end
         end
      end
      if (!finished) begin
         n_checks++;
         $display("FAIL timeout: sequence did not return to idle within 400 cycles");
      end
      tep_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; order = 2'd2; abort = 1'b1; tep_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (tep !== '0 || tep_is_2bit !== 1'b0 || tep_index !== '0 || tep_valid !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0 || tep_count !== '0)
         $display("FAIL reset: tep=%h is2=%b idx=%0d valid=%b busy=%b done=%b cnt=%0d required all zero",
                  tep, tep_is_2bit, tep_index, tep_valid, busy, done, tep_count);
      else n_pass++;
      start = 1'b0; abort = 1'b0; tep_ready = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_full(input string name, input int ord, input bit rnd, input int pulse_idx,
                           input int exp_len);
      int acc, dn;
      push_expected(ord);
      do_start(ord);
      drain(rnd, -1, pulse_idx, acc, dn);
      n_checks++;
      if (acc !== exp_len || dn !== 1 || tep_count !== IDX_W'(exp_len) || q.size() != 0)
         $display("FAIL %s: accepts=%0d dones=%0d count=%0d left=%0d required accepts=%0d dones=1 count=%0d left=0",
                  name, acc, dn, tep_count, q.size(), exp_len, exp_len);
      else n_pass++;
   endtask

   task automatic test_order2();          run_full("order2",  2, 1'b0, -1, 37); endtask
   task automatic test_order0_1();
      run_full("order0", 0, 1'b0, -1, 1);
      run_full("order1", 1, 1'b0, -1, 9);
   endtask
   task automatic test_order3();          run_full("order3",  3, 1'b0, -1, 37); endtask
   task automatic test_backpressure();    run_full("bp",      2, 1'b1, -1, 37); endtask
   task automatic test_start_ignored();   run_full("start_ignored", 2, 1'b0, 5, 37); endtask

   task automatic test_abort();
      int acc, dn;
      push_expected(2);
      do_start(2);
      drain(1'b0, 12, -1, acc, dn);
      n_checks++;
      if (dn !== 0 || tep_count !== IDX_W'(37) || acc !== 12)
         $display("FAIL abort: dones=%0d count=%0d accepts=%0d required dones=0 count=37 accepts=12",
                  dn, tep_count, acc);
      else n_pass++;
      run_full("after_abort", 1, 1'b0, -1, 9);
   endtask

   task automatic test_reset_mid();
      bit reached;
      reached = 0;
      push_expected(2);
      do_start(2);
      @(negedge clk);
      start = 1'b0;
      tep_ready = 1'b1;
      for (int c = 0; c < 100 && !reached; c++) begin
         @(negedge clk);
         if (tep_valid && tep_index == IDX_W'(20)) reached = 1;
      end
      if (!reached) begin
         n_checks++;
         $display("FAIL reset_mid_reach: index 20 not reached");
      end
      n_checks++;
      if (tep_is_2bit !== 1'b1)
         $display("FAIL reset_mid_ord2: is2=%b required 1", tep_is_2bit);
      else n_pass++;
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (tep !== '0 || tep_is_2bit !== 1'b0 || tep_index !== '0 || tep_valid !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0 || tep_count !== '0)
         $display("FAIL reset_mid: tep=%h is2=%b idx=%0d valid=%b busy=%b done=%b cnt=%0d required all zero",
                  tep, tep_is_2bit, tep_index, tep_valid, busy, done, tep_count);
      else n_pass++;
      rst_n = 1'b1;
      tep_ready = 1'b0;
      q.delete();
      @(negedge clk);
      run_full("after_reset", 0, 1'b0, -1, 1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; order = 2'd0; abort = 1'b0; tep_ready = 1'b0;
      test_reset();
      test_order2();
      test_order0_1();
      test_order3();
      test_backpressure();
      test_start_ignored();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/osd_tep_scheduler.md
# osd_tep_scheduler

Sequences the test-error-pattern (TEP) generation for the OSD decoder: on a start command it emits, one per handshake, the order-0 pattern, then all order-1 (single-bit) patterns, then all order-2 (two-bit) patterns, up to the requested order. It sits between the decoder top-level control and the candidate accumulator, and provides the accumulator's per-pattern valid and end-of-list signalling. Output flow control is a valid/ready stream, so downstream re-encoding can stall the sequence.

## Interface
- K, 8, information-set length; pattern width; legal range 2..64
- IDX_W, 16, width of tep_index and tep_count; must hold 1+K+K(K-1)/2
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a sequence; sampled only in IDLE
- order  in  2  max order, sampled with start; 0, 1, 2; value 3 treated as 2
- abort  in  1  terminate current sequence, no done pulse
- tep  out  K  current pattern, bit i = flip position i
- tep_is_2bit  out  1  current pattern is order 2
- tep_index  out  IDX_W  0-based position of current pattern in the sequence
- tep_valid  out  1  tep/tep_index/tep_is_2bit are valid
- tep_ready  in  1  consumer accepts current pattern
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the final pattern is accepted
- tep_count  out  IDX_W  patterns accepted in the last completed sequence

## Operation
- States: IDLE, ORD0, ORD1, ORD2, DONE.
- IDLE: start=1 → latch order, clear the running index, go to ORD0. start is ignored in every other state.
- ORD0: tep=0, tep_is_2bit=0. On accept → DONE if order=0, else ORD1 with bit pointer i=0.
- ORD1: tep = 1<<i. On accept: if i=K-1 → DONE if order=1, else ORD2 with (i,j)=(0,1). Otherwise i+1.
- ORD2: tep = (1<<i)|(1<<j), with i<j, lexicographic order. tep_is_2bit=1. On accept: if j<K-1, j+1. Else, if i<K-2, i+1 and j=i+2. Else → DONE.
- Accept means tep_valid & tep_ready. tep_index increments by 1 on each accept.
- DONE: done=1 for exactly one cycle. tep_count = final index. Next state is IDLE.
- tep_count is held until the next DONE. start does not clear it.
- abort=1 in ORD0, ORD1 or ORD2 → IDLE next cycle, with no done and tep_count unchanged. abort has priority over an accept in the same cycle. abort in IDLE or DONE is ignored.
- Sequence lengths: 1 for order 0, 1+K for order 1, 1+K+K(K-1)/2 for order 2 (K=8: 1, 9, 37).

## Timing
- Reset (rst_n=0 at clk edge): state=IDLE, tep=0, tep_is_2bit=0, tep_index=0, tep_valid=0, busy=0, done=0, tep_count=0. Reset overrides start and abort, and applies mid-sequence.
- start accepted at edge n → tep_valid=1 with tep=0 from cycle n+1.
- tep_valid = state in {ORD0, ORD1, ORD2}. It never drops while stalled.
- While tep_valid & !tep_ready, tep, tep_index and tep_is_2bit hold stable.
- Throughput: one pattern per cycle with tep_ready held high.
- The final accept at edge m gives done=1 in cycle m+1 and busy=0 in cycle m+2. A new start is accepted at the m+2 edge at the earliest.
- All outputs are registered. There is no combinational path from tep_ready to tep_valid.

## Structure
- Shared package osd_pkg:
  - default K
  - state enum encoding for IDLE/ORD0/ORD1/ORD2/DONE
  - constant function num_teps(K, order)
  - osd_pkg is shared with the candidate accumulator for buffer sizing.
- One natural sub-module, osd_pair_counter:
  - (i,j) pair counter with load, advance and last outputs
  - reused for single-index stepping with j unused
- The top level holds the FSM, the index counter and the output registers.

## Test plan
- K=8, order=2, tep_ready=1: 37 accepts.
  - Pattern sequence: 0x00; then 0x01,0x02,…,0x80; then 0x03,0x05,…,0x81,0x06,…,0xC0.
  - tep_is_2bit rises at index 9.
  - done pulses once; tep_count=37.
- order=0, then order=1: single pattern 0x00 with tep_count=1; then 9 patterns ending 0x80 with tep_count=9. Also order=3 behaves identically to order=2.
- Backpressure: drive tep_ready with a random 50% duty.
  - tep and tep_index stay stable during stalls.
  - No pattern is skipped or repeated; total accepts = 37.
- abort asserted at index 12 together with tep_ready=1:
  - IDLE next cycle, no done pulse.
  - tep_count retains its previous value.
  - A following start restarts at 0x00.
- rst_n=0 mid-ORD2: all outputs take reset values at the next edge. start is ignored while busy (pulse at index 5 has no effect).
